// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Handshake and data bundle for the bit-serial adder.
//   Configuration macro: SERIAL_ADDER_SUB_EN adds the 'sub' select signal.
//   Signals:
//     start    - operation request (master -> slave)
//     a, b     - WIDTH-bit operands (master -> slave)
//     sub      - subtract select, only with SERIAL_ADDER_SUB_EN (master -> slave)
//     sum      - WIDTH-bit registered result (slave -> master)
//     cout     - registered final carry-out (slave -> master)
//     overflow - registered two's-complement overflow (slave -> master)
//     busy     - high while bits are being processed (slave -> master)
//     done     - one-cycle completion pulse (slave -> master)
//   Modports: master (requester side), slave (adder side).
interface serial_adder_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;
  logic             done;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, sub, input sum, cout, overflow, busy, done);
  modport slave  (input start, a, b, sub, output sum, cout, overflow, busy, done);
`else
  modport master (output start, a, b, input sum, cout, overflow, busy, done);
  modport slave  (input start, a, b, output sum, cout, overflow, busy, done);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder (optionally subtractor). Operands are shifted out LSB
//   first through a single full_adder, one bit per clock, with a carry
//   flip-flop feeding cout back to cin. Result, carry-out and signed
//   overflow are registered at completion and held until the next one.
//   Configuration macro: SERIAL_ADDER_SUB_EN enables a - b via bus.sub.
//   Parameters:
//     WIDTH - operand/result width in bits (>= 2)
//     CNT_W - bit-counter width, derived from WIDTH (do not override)
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous active-high reset
//     bus - serial_adder_if slave modport (start/a/b/[sub] in,
//           sum/cout/overflow/busy/done out)
//
// full_adder
//   Single-bit full adder: s = a ^ b ^ cin, cout = majority(a, b, cin).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_r;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_cout;
  logic             load;
  logic             last;
  logic             sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = bus.sub;
`else
  assign sub_sel = 1'b0;
`endif

  full_adder u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Next-state logic. A start is accepted from IDLE and also from DONE, so
  // back-to-back operations lose no cycle; start during RUN is ignored.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_BIT) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath. Subtraction is a + ~b + 1: invert B at load and seed the carry
  // with 1. On the last bit the carry register still holds the carry into the
  // MSB, so overflow is simply carry ^ fa_cout on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a         <= '0;
      sh_b         <= '0;
      sh_r         <= '0;
      carry        <= 1'b0;
      cnt          <= '0;
      bus.sum      <= '0;
      bus.cout     <= 1'b0;
      bus.overflow <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.done <= last;
      if (load) begin
        sh_a     <= bus.a;
        sh_b     <= sub_sel ? ~bus.b : bus.b;
        carry    <= sub_sel;
        cnt      <= '0;
        bus.busy <= 1'b1;
      end else if (state == RUN) begin
        sh_r  <= {fa_s, sh_r[WIDTH-1:1]};
        sh_a  <= sh_a >> 1;
        sh_b  <= sh_b >> 1;
        carry <= fa_cout;
        cnt   <= cnt + 1'b1;
        if (last) begin
          bus.sum      <= {fa_s, sh_r[WIDTH-1:1]};
          bus.cout     <= fa_cout;
          bus.overflow <= carry ^ fa_cout;
          bus.busy     <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Self-checking bench for serial_adder at WIDTH=8. Expected results come
//   from integer arithmetic on the operands (unsigned sum for carry, signed
//   sum for overflow). Directed cases cover reset, carry/overflow, back-to-back
//   starts, start-while-busy, mid-run reset; a random loop follows.
//   Subtraction cases are built only with SERIAL_ADDER_SUB_EN.
module tb_serial_adder;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] prev_sum;
  logic             prev_cout;
  logic             prev_ovf;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference arithmetic: plain integer add/subtract of the operands.
  task automatic model(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in,
                       input bit sub_in, output logic [WIDTH-1:0] es,
                       output logic ec, output logic eo);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a_in);
    ub = int'(b_in);
    sa = int'($signed(a_in));
    sb = int'($signed(b_in));
    if (sub_in) begin
      ur = ua - ub;
      sr = sa - sb;
      ec = (ua >= ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      ec = (ur > 255);
    end
    es = ur[WIDTH-1:0];
    eo = (sr > 127) || (sr < -128);
  endtask

  // Present operands with a one-cycle start pulse, then scramble the
  // operand inputs so a late re-capture would corrupt the result.
  task automatic applyStimulus(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in);
    bus.a     = a_in;
    bus.b     = b_in;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
  endtask

  // Run one operation and check every cycle. start is re-driven with junk
  // operands for RUN cycle indices hold_lo..hold_hi. With chain=1 the task
  // returns on the done cycle so the caller can start the next operation.
  task automatic runOp(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in,
                       input bit sub_in, input int hold_lo, input int hold_hi,
                       input bit chain);
    logic [WIDTH-1:0] es;
    logic             ec;
    logic             eo;
    model(a_in, b_in, sub_in, es, ec, eo);
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = sub_in;
`endif
    applyStimulus(a_in, b_in);
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = ~sub_in;
`endif
    for (int i = 0; i < WIDTH; i++) begin
      checkOutput("busy_run", 64'(bus.busy), 64'(1'b1));
      checkOutput("done_run", 64'(bus.done), 64'(1'b0));
      checkOutput("sum_hold", 64'(bus.sum), 64'(prev_sum));
      checkOutput("cout_hold", 64'(bus.cout), 64'(prev_cout));
      checkOutput("ovf_hold", 64'(bus.overflow), 64'(prev_ovf));
      if (i >= hold_lo && i <= hold_hi) begin
        bus.start = 1'b1;
        bus.a     = WIDTH'($urandom);
        bus.b     = WIDTH'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    checkOutput("done_pulse", 64'(bus.done), 64'(1'b1));
    checkOutput("busy_done", 64'(bus.busy), 64'(1'b0));
    checkOutput("sum", 64'(bus.sum), 64'(es));
    checkOutput("cout", 64'(bus.cout), 64'(ec));
    checkOutput("overflow", 64'(bus.overflow), 64'(eo));
    prev_sum  = es;
    prev_cout = ec;
    prev_ovf  = eo;
    if (!chain) begin
      @(negedge clk);
      checkOutput("done_drop", 64'(bus.done), 64'(1'b0));
      checkOutput("busy_idle", 64'(bus.busy), 64'(1'b0));
      checkOutput("sum_idle", 64'(bus.sum), 64'(es));
    end
  endtask

  initial begin
    bit rand_sub;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_sum", 64'(bus.sum), 64'h0);
    checkOutput("rst_cout", 64'(bus.cout), 64'h0);
    checkOutput("rst_ovf", 64'(bus.overflow), 64'h0);
    checkOutput("rst_busy", 64'(bus.busy), 64'h0);
    checkOutput("rst_done", 64'(bus.done), 64'h0);
    rst       = 1'b0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    prev_ovf  = 1'b0;
    @(negedge clk);

    // Basic add.
    runOp(8'h05, 8'h03, 1'b0, 1, 0, 1'b0);

    // Back-to-back: second start lands in the first operation's done cycle.
    runOp(8'hFF, 8'h01, 1'b0, 1, 0, 1'b1);
    runOp(8'h7F, 8'h01, 1'b0, 1, 0, 1'b0);

    // start held high with new operands during RUN must be ignored.
    runOp(8'h21, 8'h12, 1'b0, 1, 5, 1'b0);

    // Reset in the 4th RUN cycle aborts the operation with no done pulse.
    applyStimulus(8'h33, 8'h44);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_sum", 64'(bus.sum), 64'h0);
    checkOutput("abort_cout", 64'(bus.cout), 64'h0);
    checkOutput("abort_ovf", 64'(bus.overflow), 64'h0);
    checkOutput("abort_busy", 64'(bus.busy), 64'h0);
    checkOutput("abort_done", 64'(bus.done), 64'h0);
    prev_sum  = '0;
    prev_cout = 1'b0;
    prev_ovf  = 1'b0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(negedge clk);
      checkOutput("abort_no_done", 64'(bus.done), 64'h0);
    end
    runOp(8'h10, 8'h20, 1'b0, 1, 0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    runOp(8'h05, 8'h07, 1'b1, 1, 0, 1'b0);
    runOp(8'h80, 8'h01, 1'b1, 1, 0, 1'b0);
    runOp(8'h09, 8'h09, 1'b1, 1, 0, 1'b0);
`endif

    // Random operations, alternating chained and idle-separated starts.
    for (int n = 0; n < 24; n++) begin
`ifdef SERIAL_ADDER_SUB_EN
      rand_sub = bit'($urandom_range(1, 0));
`else
      rand_sub = 1'b0;
`endif
      runOp(WIDTH'($urandom), WIDTH'($urandom), rand_sub, 1, 0, (n % 2) == 0);
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder/subtractor built around the team's existing single-bit `full_adder`, which is instantiated exactly once.
- Adds two WIDTH-bit operands LSB-first, one bit per clock; a carry flip-flop closes the loop between `cout` and `cin`.
- It is the sequential stage directly downstream of the full adder: a small-area alternative to the ripple adder in the ALU.
- Uses a start/busy/done handshake and reports sum, carry-out and signed overflow.

Parameters:
- WIDTH, 64, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- sub  input  1  subtract select; captured on an accepted start (present only with SUB_EN).
- sum  output  WIDTH  registered result.
- cout  output  1  registered final carry-out.
- overflow  output  1  registered signed overflow.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset (any cycle, including mid-operation):
  - state=IDLE.
  - sum=0, cout=0, overflow=0, busy=0, done=0.
  - Shift registers, carry flip-flop and counter cleared.
  - An in-flight operation is aborted; done is never raised for it.
- States: IDLE, RUN, DONE.
- IDLE, or DONE, with start=1:
  - Load shA<=a, shB<=b, carry<=0, cnt<=0, busy<=1.
  - Go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, each cycle:
  - full_adder inputs: a=shA[0], b=shB[0], cin=carry.
  - shR <= {s, shR[WIDTH-1:1]}.
  - shA and shB shift right by 1.
  - carry <= cout.
  - cnt <= cnt+1.
  - On the cycle that processes bit WIDTH-1, also capture cprev = carry (the carry into the MSB).
- RUN → DONE on the edge that processes the last bit (cnt==WIDTH-1). On that edge:
  - sum <= final shR value, including the last s bit.
  - cout <= full_adder cout.
  - overflow <= cprev XOR cout.
  - busy <= 0, done <= 1.
- DONE:
  - done is high for exactly one cycle.
  - Then go to IDLE, unless start=1 is accepted as above, which goes straight to RUN with done dropping.
- Latency:
  - An accepted start at edge N gives done=1 during the cycle after edge N+WIDTH.
  - busy is high from edge N+1 through edge N+WIDTH.
- start while busy=1 is ignored; operands are not re-captured.
- sum, cout and overflow change only at completion (and at reset). They hold their values through IDLE and through subsequent RUN cycles until the next completion.
- Arithmetic is modulo 2^WIDTH. cout is the unsigned carry. overflow is the two's-complement overflow.
- a, b and sub may change freely after capture without affecting the operation in progress.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Port `sub` exists and is captured at start.
  - If sub=1: load shB<=~b and carry<=1, so the result is a−b.
  - cout=1 means no borrow.
  - overflow uses the same cprev XOR cout rule.
- Undefined:
  - No `sub` port.
  - Add only; carry always loads 0.

Test Plan:
- Bench overrides WIDTH=8.
- Reset: assert rst for 2 cycles → sum=8'h00, cout=0, overflow=0, busy=0, done=0.
- Basic add: a=8'h05, b=8'h03, start pulse → busy for 8 cycles, then done for 1 cycle; sum=8'h08, cout=0, overflow=0.
- Carry and overflow, run back-to-back:
  - 8'hFF+8'h01 → sum=8'h00, cout=1, overflow=0.
  - 8'h7F+8'h01 → sum=8'h80, cout=0, overflow=1.
  - The second start is issued during the first operation's done cycle and must be accepted.
- Busy/abort:
  - start held high with new operands during RUN → ignored; first result unchanged.
  - Separate run: rst asserted at the 4th RUN cycle → all outputs 0, no done pulse; a following 8'h10+8'h20 gives 8'h30.
- SERIAL_ADDER_SUB_EN:
  - 8'h05−8'h07 → sum=8'hFE, cout=0, overflow=0.
  - 8'h80−8'h01 → sum=8'h7F, cout=1, overflow=1.
  - 8'h09−8'h09 → sum=8'h00, cout=1.
